cellram_arbiter: RTL
====================

Name: cellram_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer in front of cellRamController.
- Accepts word read/write requests from two clients and serialises them onto the controller's wOP/iAddr/iData/oReady interface.
- Holds each op code for a fixed number of cycles, waits for completion, then returns read data and a per-port done pulse.
- Detects a hung controller with a timeout.

Parameters:
- HOLD_CYCLES, 2: cycles the op code stays driven before returning to OP_NULL; legal range ≥1.
- TIMEOUT, 64: max cycles in WAIT before the timeout abort.
- CNT_W, 7: counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, TIMEOUT).

Ports:
- iClock in 1: system clock.
- iReset in 1: synchronous, active-high reset.
- iReq0 in 1: port 0 request; held with stable fields until oGnt0.
- iWe0 in 1: port 0, 1=write, 0=read.
- iAddr0 in 23: port 0 word address.
- iData0 in 16: port 0 write data.
- oGnt0 out 1: one-cycle pulse, port 0 request accepted.
- oDone0 out 1: one-cycle pulse, port 0 op complete.
- iReq1, iWe1, iAddr1, iData1, oGnt1, oDone1: same as port 0, for port 1.
- oRdData out 16: read data, valid while oDoneN is high.
- oTimeout out 1: one-cycle pulse alongside oDoneN when the op was aborted.
- oOp out 3: to controller wOP.
- oAddr out 23: to controller iAddr.
- oData out 16: to controller iData.
- iReady in 1: from controller oReady.
- iRamData in 16: controller read data bus, sampled only.

Behaviour:
- Reset (synchronous, iReset=1 at a posedge):
  - State=INIT; oOp=OP_NULL; oAddr, oData, oRdData=0.
  - All oGnt/oDone/oTimeout=0.
  - Round-robin pointer: last=1, so port 0 wins first.
  - Reset mid-operation aborts silently: no done pulse, oOp goes to OP_NULL at the next edge.
- States: INIT, IDLE, ISSUE, WAIT, DONE.
- INIT: oOp=OP_NULL; go to IDLE on the first cycle iReady=1.
- IDLE: arbitrate only when iReady=1 and at least one iReqN=1.
  - Single requester wins.
  - Both requesting: the port ≠ last wins; last updates to the winner.
  - Winner's iWe/iAddr/iData are captured.
  - Next cycle: oGntN=1 (one cycle), state=ISSUE.
- ISSUE: lasts HOLD_CYCLES cycles. Counter loads HOLD_CYCLES-1 on entry.
  - oOp=OP_ASYNC_WRITE (4) if iWe else OP_ASYNC_READ (3).
  - oAddr/oData hold the captured values.
  - When the counter reaches 0, go to WAIT.
  - sawBusy flag clears on entry and sets on any cycle with iReady=0.
- WAIT: oOp=OP_NULL; oAddr/oData unchanged. Counter starts at 0 and increments.
  - iReady=0 sets sawBusy.
  - Completion: iReady=1 with sawBusy=1 → latch oRdData←iRamData (reads only; writes leave oRdData unchanged), go to DONE.
  - Timeout: counter reaches TIMEOUT-1 without completion → oTimeout=1 in DONE, oRdData unchanged.
- DONE: one cycle.
  - oDoneN=1 for the served port, with oTimeout as above.
  - Next: IDLE.
- Throughput: completion-to-next-grant is 2 cycles (DONE → IDLE arbitrate → grant).
- Request rules:
  - Deasserting iReqN before its grant withdraws the request; no grant is issued.
  - A request held through DONE is re-arbitrated normally; a requester wanting one op must drop iReq on oGnt.
  - Requests arriving during ISSUE/WAIT/DONE wait in IDLE.
- Exclusivity: oGnt0/oGnt1 are never both high; same for oDone0/oDone1. Exactly one oDone per oGnt unless reset intervenes.
- Control-register ops (OP_READ_CTRL/OP_WRITE_CTRL) are not issued by this block.

Decomposition:
- Shared package cellram_pkg:
  - OP_NULL=0, OP_READ_CTRL=1, OP_WRITE_CTRL=2, OP_ASYNC_READ=3, OP_ASYNC_WRITE=4.
  - State encoding constants.
- The controller testbench imports cellram_pkg as well.
- One sub-module: rr_arb2 (combinational grant from req[1:0] and last; registered pointer update stays in the parent).

Test Plan:
- Reset hold: iReady=0 for 5 cycles after reset with iReq0=1 → no oGnt0 and oOp=0 throughout; iReady rises → oGnt0 pulses 2 cycles later.
- Single write: port 0 write addr 0x000005 data 0xBEEF; controller model drops ready for 4 cycles.
  - oOp=4, oAddr=0x000005, oData=0xBEEF for exactly 2 cycles.
  - Then oOp=0; oDone0 pulses once; oRdData unchanged.
- Single read: port 1 read addr 0x000005; model returns 0xBEEF → oOp=3 for 2 cycles; oDone1 with oRdData=0xBEEF.
- Contention: both ports hold iReq continuously for 4 ops each → grant order 0,1,0,1,0,1,0,1; never both grants high.
- Timeout: model keeps iReady=1 (never busy) after a read issue → oDone0 and oTimeout high TIMEOUT+1 cycles after ISSUE ends; next request is still served.
- Reset mid-op: assert iReset during WAIT → next edge oOp=0, no oDone, state INIT; a subsequent port 0 request completes normally.

Source files
------------

// File: rtl/cellram_pkg.sv
// Shared definitions for the cellRAM controller and its front-end arbiter.
// Holds the controller op codes, the arbiter state encoding, the captured
// request record and a helper that maps a write-enable to an async op code.
package cellram_pkg;

  // Controller wOP encodings
  localparam logic [2:0] OP_NULL        = 3'd0;
  localparam logic [2:0] OP_READ_CTRL   = 3'd1;
  localparam logic [2:0] OP_WRITE_CTRL  = 3'd2;
  localparam logic [2:0] OP_ASYNC_READ  = 3'd3;
  localparam logic [2:0] OP_ASYNC_WRITE = 3'd4;

  // Arbiter sequencer states
  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic [15:0] data;
  } cr_req_t;

  function automatic logic [2:0] op_for(input logic we);
    return we ? OP_ASYNC_WRITE : OP_ASYNC_READ;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req  : request vector {port1, port0}
//   last : port that won the previous arbitration
//   gnt  : one-hot grant (zero when nobody requests)
// The pointer register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On contention the port that did not win last time goes first.
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cellram_arbiter.sv
// Two-requester round-robin sequencer in front of cellRamController.
// Serialises word read/write requests onto the wOP/iAddr/iData/oReady
// interface, holds each op code for HOLD_CYCLES, waits for the controller
// to go busy and come back ready, then pulses the per-port done.  A
// controller that never goes busy is aborted after TIMEOUT wait cycles.
// Ports:
//   iClock, iReset             : clock, synchronous active-high reset
//   iReqN/iWeN/iAddrN/iDataN   : client request N (held until oGntN)
//   oGntN, oDoneN              : one-cycle accept / complete pulses
//   oRdData, oTimeout          : read data and abort flag, valid with oDoneN
//   oOp/oAddr/oData            : to controller wOP/iAddr/iData
//   iReady, iRamData           : from controller oReady / read data bus
module cellram_arbiter
  import cellram_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 7
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReq0,
  input  logic        iWe0,
  input  logic [22:0] iAddr0,
  input  logic [15:0] iData0,
  output logic        oGnt0,
  output logic        oDone0,
  input  logic        iReq1,
  input  logic        iWe1,
  input  logic [22:0] iAddr1,
  input  logic [15:0] iData1,
  output logic        oGnt1,
  output logic        oDone1,
  output logic [15:0] oRdData,
  output logic        oTimeout,
  output logic [2:0]  oOp,
  output logic [22:0] oAddr,
  output logic [15:0] oData,
  input  logic        iReady,
  input  logic [15:0] iRamData
);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last;      // port served most recently
  logic             port;      // port currently being served
  logic             cur_we;
  logic             saw_busy;  // controller has dropped ready for this op
  logic [1:0]       gnt;
  cr_req_t          sel;

  rr_arb2 u_arb (
    .req  ({iReq1, iReq0}),
    .last (last),
    .gnt  (gnt)
  );

  always_comb begin
    sel = gnt[1] ? '{we: iWe1, addr: iAddr1, data: iData1}
                 : '{we: iWe0, addr: iAddr0, data: iData0};
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state    <= ST_INIT;
      cnt      <= '0;
      last     <= 1'b1;
      port     <= 1'b0;
      cur_we   <= 1'b0;
      saw_busy <= 1'b0;
      oOp      <= OP_NULL;
      oAddr    <= '0;
      oData    <= '0;
      oRdData  <= '0;
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oDone0   <= 1'b0;
      oDone1   <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      // Pulse outputs default low; set for exactly one cycle below.
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oDone0   <= 1'b0;
      oDone1   <= 1'b0;
      oTimeout <= 1'b0;
      case (state)
        ST_INIT: if (iReady) state <= ST_IDLE;
        ST_IDLE: begin
          if (iReady && (|gnt)) begin
            port     <= gnt[1];
            last     <= gnt[1];
            cur_we   <= sel.we;
            oOp      <= op_for(sel.we);
            oAddr    <= sel.addr;
            oData    <= sel.data;
            oGnt0    <= gnt[0];
            oGnt1    <= gnt[1];
            cnt      <= CNT_W'(HOLD_CYCLES - 1);
            saw_busy <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!iReady) saw_busy <= 1'b1;
          if (cnt == '0) begin
            oOp   <= OP_NULL;
            cnt   <= '0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          // Ready alone is not completion: the controller must first have
          // gone busy, otherwise a stale ready would end the op early.
          if (iReady && saw_busy) begin
            if (!cur_we) oRdData <= iRamData;
            oDone0 <= ~port;
            oDone1 <= port;
            state  <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            oDone0   <= ~port;
            oDone1   <= port;
            oTimeout <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (!iReady) saw_busy <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
